// File: rtl/mem_responder.sv
// Word-addressed data-memory responder with configurable wait states and response back-pressure.
// Define MEM_RESP_ALIGN_CHECK_EN to flag misaligned (addr[1:0] != 0) requests as errors.
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic             lat_write;
   logic [31:0]      lat_addr;
   logic [31:0]      lat_wdata;
   logic [31:0]      mem [DEPTH_WORDS];

   logic             in_range;
   logic             req_bad;
   logic             commit;
   logic             do_store;
   logic [IDX_W-1:0] mem_idx;

   // Full 30-bit word index is compared so high addresses never alias into storage.
   assign in_range = lat_addr[31:2] < DEPTH_IDX;

`ifdef MEM_RESP_ALIGN_CHECK_EN
   assign req_bad = !in_range || (lat_addr[1:0] != 2'b00);
`else
   logic unused_align_bits;
   assign unused_align_bits = ^lat_addr[1:0];
   assign req_bad = !in_range;
`endif

   assign commit   = (state == WAIT) && (wait_cnt == 4'd0);
   assign do_store = commit && lat_write && !req_bad && !reset;
   assign mem_idx  = lat_addr[IDX_W+1:2];

   always_ff @(posedge clk) begin
      if (do_store) begin
         mem[mem_idx] <= lat_wdata;
      end
   end

   // Every request passes through WAIT, so the response appears LATENCY+1 edges after acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         wait_cnt   <= 4'd0;
         lat_write  <= 1'b0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  wait_cnt  <= 4'(LATENCY);
                  req_ready <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= req_bad;
                  resp_rdata <= (lat_write || req_bad) ? 32'd0 : mem[mem_idx];
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_rdata <= 32'd0;
                  resp_err   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
